button_debouncer: RTL and testbench

- Conditions one raw mechanical push-button or sensor contact input before the rising-edge detector stage.
- Synchronises the asynchronous pin into clk_i with a flop chain.
- Filters contact bounce with a stable-time counter and state machine, and presents a clean level on button_o.
- Also produces single-cycle press/release strobes. The edge detector downstream consumes button_o directly.

---
 rtl/button_debouncer_if.sv | 22 ++
 rtl/button_debouncer.sv | 143 ++++++++++++++
 tb/tb_button_debouncer.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/button_debouncer_if.sv
// Pin-side signal bundle for button_debouncer: raw contact in, debounced level and strobes out.
// The master drives the raw pin and consumes the conditioned outputs; the debouncer is the slave.
interface button_debouncer_if;
    logic button_i;
    logic button_o;
    logic press_o;
    logic release_o;

    modport master (
        output button_i,
        input  button_o,
        input  press_o,
        input  release_o
    );

    modport slave (
        input  button_i,
        output button_o,
        output press_o,
        output release_o
    );
endinterface

// File: rtl/button_debouncer.sv
// Contact debouncer: flop-chain synchronizer, stable-time filter FSM, registered level and
// one-cycle press/release strobes that change in the same cycle as the level.
//
//   state       | meaning
//   ------------+---------------------------------------------------------------
//   STABLE_LOW  | output low, synchronized input agrees
//   WAIT_HIGH   | output low, input high; counting consecutive high samples
//   STABLE_HIGH | output high, synchronized input agrees
//   WAIT_LOW    | output high, input low; counting consecutive low samples
module button_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 100000,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input logic               clk_i,
    input logic               rst_ni,
    button_debouncer_if.slave bus
);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        WAIT_HIGH   = 2'b01,
        STABLE_HIGH = 2'b10,
        WAIT_LOW    = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;

    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   press_q;
    logic                   press_d;
    logic                   release_q;
    logic                   release_d;

    // Only the first stage ever sees the raw pin.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.button_i};
        end
    end

    assign btn_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= STABLE_LOW;
            cnt_q     <= CNT_ZERO;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Terminal compare uses >= so a corrupted count can only shorten the wait, never wrap it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;

        case (state_q)
            STABLE_LOW: begin
                level_d = 1'b0;
                if (btn_s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end

            WAIT_HIGH: begin
                level_d = 1'b0;
                if (!btn_s) begin
                    state_d = STABLE_LOW;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q >= CNT_MAX) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = CNT_ZERO;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end

            STABLE_HIGH: begin
                level_d = 1'b1;
                if (!btn_s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end

            WAIT_LOW: begin
                level_d = 1'b1;
                if (btn_s) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q >= CNT_MAX) begin
                    state_d   = STABLE_LOW;
                    cnt_d     = CNT_ZERO;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d     = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = STABLE_LOW;
                cnt_d   = CNT_ZERO;
                level_d = 1'b0;
            end
        endcase
    end

    assign bus.button_o  = level_q;
    assign bus.press_o   = press_q;
    assign bus.release_o = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: expected level/strobe events are queued as stimulus is driven
// and matched in order against events seen at the falling clock edge.
`timescale 1ns/1ps
module tb_button_debouncer;

    typedef struct packed {
        logic [31:0] cyc;
        logic        p;
        logic        r;
        logic        b;
    } ev_t;

    localparam int SMALL_STABLE = 4;
    localparam int BIG_STABLE   = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;
    logic prev_b   = 1'b0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];

    button_debouncer_if bif();
    button_debouncer_if bif_big();

    button_debouncer #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(SMALL_STABLE)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bif)
    );

    button_debouncer #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(BIG_STABLE)
    ) dut_big (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bif_big)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input int c, input logic p, input logic r, input logic b);
        ev_t e;
        e.cyc = 32'(c);
        e.p   = p;
        e.r   = r;
        e.b   = b;
        return e;
    endfunction

    // Record every strobe and every level change of the small instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_b = 1'b0;
        end else begin
            if (bif.press_o || bif.release_o || (bif.button_o !== prev_b))
                obs_q.push_back(mk(cyc, bif.press_o, bif.release_o, bif.button_o));
            prev_b = bif.button_o;
        end
        checks++;
        if ((dut.cnt_q > 3'(SMALL_STABLE)) || (dut_big.cnt_q > 10'(BIG_STABLE)) ||
            (bif.press_o && bif.release_o) || (bif_big.press_o && bif_big.release_o)) begin
            failures++;
            $display("FAIL invariant cyc=%0d cnt=%0d cnt_big=%0d p=%b r=%b", cyc,
                     dut.cnt_q, dut_big.cnt_q, bif.press_o, bif.release_o);
        end
    end

    // Park at the falling edge after edge k.
    task automatic goto(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    // Make v the value sampled by the synchronizer at edge k.
    task automatic drive_at(input int k, input logic v);
        goto(k - 1);
        bif.button_i = v;
    endtask

    task automatic test_reset();
        ev_t e, o;
        int  r;
        bif.button_i = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bif.button_o !== 1'b0) begin
            failures++; $display("FAIL reset_button_o got %b want 0", bif.button_o);
        end
        checks++;
        if (bif.press_o !== 1'b0) begin
            failures++; $display("FAIL reset_press_o got %b want 0", bif.press_o);
        end
        checks++;
        if (bif.release_o !== 1'b0) begin
            failures++; $display("FAIL reset_release_o got %b want 0", bif.release_o);
        end
        r = cyc;
        rst_n = 1'b1;
        exp_q.push_back(mk(r + 7, 1'b1, 1'b0, 1'b1));
        goto(r + 14);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL reset_missing want cyc=%0d p=%b r=%b b=%b", e.cyc, e.p, e.r, e.b);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL reset_event got cyc=%0d p=%b r=%b b=%b want cyc=%0d p=%b r=%b b=%b",
                             o.cyc, o.p, o.r, o.b, e.cyc, e.p, e.r, e.b);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++; $display("FAIL reset_extra got %0d want 0 events", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_async_reset_high();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bif.button_o !== 1'b0) begin
            failures++; $display("FAIL async_drop_button_o got %b want 0", bif.button_o);
        end
        bif.button_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        goto(cyc + 12);
        checks++;
        if (obs_q.size() != 0) begin
            failures++; $display("FAIL async_extra got %0d want 0 events", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_clean();
        ev_t e, o;
        int  base;
        base = cyc;
        drive_at(base + 10, 1'b1);
        exp_q.push_back(mk(base + 16, 1'b1, 1'b0, 1'b1));
        drive_at(base + 30, 1'b0);
        exp_q.push_back(mk(base + 36, 1'b0, 1'b1, 1'b0));
        goto(base + 45);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL clean_missing want cyc=%0d p=%b r=%b b=%b", e.cyc, e.p, e.r, e.b);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL clean_event got cyc=%0d p=%b r=%b b=%b want cyc=%0d p=%b r=%b b=%b",
                             o.cyc, o.p, o.r, o.b, e.cyc, e.p, e.r, e.b);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++; $display("FAIL clean_extra got %0d want 0 events", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_bounce();
        ev_t e, o;
        int  base;
        logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        base = cyc;
        for (int i = 0; i < 5; i++) drive_at(base + 10 + i, pat[i]);
        exp_q.push_back(mk(base + 20, 1'b1, 1'b0, 1'b1));
        drive_at(base + 30, 1'b0);
        exp_q.push_back(mk(base + 36, 1'b0, 1'b1, 1'b0));
        goto(base + 45);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL bounce_missing want cyc=%0d p=%b r=%b b=%b", e.cyc, e.p, e.r, e.b);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL bounce_event got cyc=%0d p=%b r=%b b=%b want cyc=%0d p=%b r=%b b=%b",
                             o.cyc, o.p, o.r, o.b, e.cyc, e.p, e.r, e.b);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++; $display("FAIL bounce_extra got %0d want 0 events", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_glitch();
        ev_t e, o;
        int  base;
        base = cyc;
        drive_at(base + 10, 1'b1);
        drive_at(base + 13, 1'b0);
        drive_at(base + 30, 1'b1);
        drive_at(base + 34, 1'b0);
        drive_at(base + 50, 1'b1);
        drive_at(base + 55, 1'b0);
        exp_q.push_back(mk(base + 56, 1'b1, 1'b0, 1'b1));
        exp_q.push_back(mk(base + 61, 1'b0, 1'b1, 1'b0));
        drive_at(base + 70, 1'b1);
        exp_q.push_back(mk(base + 76, 1'b1, 1'b0, 1'b1));
        drive_at(base + 80, 1'b0);
        drive_at(base + 83, 1'b1);
        drive_at(base + 90, 1'b0);
        exp_q.push_back(mk(base + 96, 1'b0, 1'b1, 1'b0));
        goto(base + 105);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL glitch_missing want cyc=%0d p=%b r=%b b=%b", e.cyc, e.p, e.r, e.b);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL glitch_event got cyc=%0d p=%b r=%b b=%b want cyc=%0d p=%b r=%b b=%b",
                             o.cyc, o.p, o.r, o.b, e.cyc, e.p, e.r, e.b);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++; $display("FAIL glitch_extra got %0d want 0 events", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_reset_mid_wait();
        ev_t e, o;
        int  base, r;
        base = cyc;
        drive_at(base + 10, 1'b1);
        goto(base + 14);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bif.button_o, bif.press_o, bif.release_o} !== 3'b000) begin
            failures++;
            $display("FAIL midwait_outputs got %b%b%b want 000", bif.button_o, bif.press_o, bif.release_o);
        end
        repeat (2) @(negedge clk);
        r = cyc;
        rst_n = 1'b1;
        exp_q.push_back(mk(r + 7, 1'b1, 1'b0, 1'b1));
        drive_at(r + 20, 1'b0);
        exp_q.push_back(mk(r + 26, 1'b0, 1'b1, 1'b0));
        goto(r + 35);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL midwait_missing want cyc=%0d p=%b r=%b b=%b", e.cyc, e.p, e.r, e.b);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL midwait_event got cyc=%0d p=%b r=%b b=%b want cyc=%0d p=%b r=%b b=%b",
                             o.cyc, o.p, o.r, o.b, e.cyc, e.p, e.r, e.b);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++; $display("FAIL midwait_extra got %0d want 0 events", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_long_filter();
        int base, lat;
        base = cyc;
        lat  = 2 + BIG_STABLE;
        goto(base + 9);
        bif_big.button_i = 1'b1;
        goto(base + 10 + lat - 1);
        checks++;
        if (bif_big.button_o !== 1'b0) begin
            failures++; $display("FAIL long_early got %b want 0", bif_big.button_o);
        end
        goto(base + 10 + lat);
        checks++;
        if ({bif_big.button_o, bif_big.press_o, bif_big.release_o} !== 3'b110) begin
            failures++;
            $display("FAIL long_press got %b%b%b want 110", bif_big.button_o, bif_big.press_o, bif_big.release_o);
        end
        goto(base + 10 + lat + 1);
        checks++;
        if ({bif_big.button_o, bif_big.press_o} !== 2'b10) begin
            failures++; $display("FAIL long_strobe_width got %b%b want 10", bif_big.button_o, bif_big.press_o);
        end
        goto(base + 1099);
        bif_big.button_i = 1'b0;
        goto(base + 1100 + lat - 1);
        checks++;
        if (bif_big.button_o !== 1'b1) begin
            failures++; $display("FAIL long_early_release got %b want 1", bif_big.button_o);
        end
        goto(base + 1100 + lat);
        checks++;
        if ({bif_big.button_o, bif_big.press_o, bif_big.release_o} !== 3'b001) begin
            failures++;
            $display("FAIL long_release got %b%b%b want 001", bif_big.button_o, bif_big.press_o, bif_big.release_o);
        end
    endtask

    initial begin
        bif.button_i     = 1'b0;
        bif_big.button_i = 1'b0;
        test_reset();
        test_async_reset_high();
        test_clean();
        test_bounce();
        test_glitch();
        test_reset_mid_wait();
        test_long_filter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog cyc=%0d limit reached", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
